imem_loader: RTL and testbench

- Boot-time program loader that sits directly upstream of the 5-stage RISC-V pipeline core and feeds its instruction memory.
- Accepts a byte stream with a valid/ready handshake (e.g. from a UART receiver) and assembles little-endian 32-bit instruction words.
- Writes each word into instruction memory and verifies a trailing checksum.
- Holds the core in reset until a good image is loaded; the core's `rst` is driven from this block's `core_rst` output.

---
 rtl/loader_pkg.sv | 6 +
 rtl/byte_packer.sv | 28 ++
 rtl/imem_loader.sv | 81 ++++++++
 tb/tb_imem_loader.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and word/checksum constants for the program loader.
package loader_pkg;
    typedef enum logic [2:0] {ST_LEN, ST_DATA, ST_CSUM, ST_DONE, ST_ERR} state_t;
    localparam int BYTES_PER_WORD = 4;
    localparam int CSUM_W = 32;
endpackage

// File: rtl/byte_packer.sv
// byte_packer: assembles little-endian 32-bit words from a stream of accepted bytes.
module byte_packer
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_accept,
    input  logic [7:0]        i_byte,
    output logic              o_word_valid,
    output logic [CSUM_W-1:0] o_word
);
    logic [1:0]  r_cnt;
    logic [23:0] r_low;

    // Low three bytes shift in from the top; the fourth byte completes the word combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_low <= '0;
        end else if (i_accept) begin
            r_cnt <= r_cnt + 2'd1;
            r_low <= {i_byte, r_low[23:8]};
        end
    end

    assign o_word_valid = i_accept && (r_cnt == 2'(BYTES_PER_WORD - 1));
    assign o_word       = {i_byte, r_low};
endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed, checksummed word image into instruction memory
// and releases the core from reset once the image verifies.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);
    state_t              r_state, w_next;
    logic [ADDR_W:0]     r_len;
    logic [CSUM_W-1:0]   r_csum;
    logic                w_accept, w_word_valid, w_len_bad, w_last;
    logic [CSUM_W-1:0]   w_word;

    assign in_ready = (r_state == ST_LEN) || (r_state == ST_DATA) || (r_state == ST_CSUM);
    assign w_accept = in_valid && in_ready;
    assign done     = (r_state == ST_DONE);
    assign error    = (r_state == ST_ERR);
    assign core_rst = (r_state != ST_DONE);

    byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_accept     (w_accept),
        .i_byte       (in_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    assign w_len_bad = (w_word == '0) || (w_word > 32'(MAX_WORDS));
    // words_loaded still holds the count before the write of the word completing now.
    assign w_last    = (words_loaded + 1'b1) == r_len;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_LEN:  if (w_word_valid) w_next = w_len_bad ? ST_ERR : ST_DATA;
            ST_DATA: if (w_word_valid && w_last) w_next = ST_CSUM;
            ST_CSUM: if (w_word_valid) w_next = (w_word == r_csum) ? ST_DONE : ST_ERR;
            ST_DONE: w_next = ST_DONE;
            ST_ERR:  w_next = ST_ERR;
            default: w_next = ST_ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_LEN;
            r_len        <= '0;
            r_csum       <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            words_loaded <= '0;
        end else begin
            r_state <= w_next;
            imem_we <= (r_state == ST_DATA) && w_word_valid;
            if ((r_state == ST_LEN) && w_word_valid && !w_len_bad)
                r_len <= w_word[ADDR_W:0];
            if ((r_state == ST_DATA) && w_word_valid) begin
                imem_addr    <= words_loaded[ADDR_W-1:0];
                imem_wdata   <= w_word;
                words_loaded <= words_loaded + 1'b1;
                r_csum       <= r_csum + w_word;
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven and randomized image loads checked against an image-level model.
module tb_imem_loader;
    localparam int ADDR_W = 10;
    localparam int MAXW = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = '0;
    logic              in_ready, imem_we, core_rst, done, error;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   words_loaded;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic [31:0] len;
        logic [31:0] w0;
        logic [31:0] step;
        logic [31:0] cdelta;
        int          maxgap;
        bit          exp_done;
        bit          exp_err;
    } vec_t;
    vec_t tbl[7];

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst(core_rst), .done(done), .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Every write pulse must be the next entry of the expected write list.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%03h data 0x%08h expected none", imem_addr, imem_wdata);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("write_addr", 32'(imem_addr), w.addr);
                check("write_data", imem_wdata, w.data);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom_range(0, 255);
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], $urandom_range(0, maxgap));
    endtask

    task automatic check_reset_vals();
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_imem_we", 32'(imem_we), 0);
        check("rst_imem_addr", 32'(imem_addr), 0);
        check("rst_imem_wdata", imem_wdata, 0);
        check("rst_core_rst", 32'(core_rst), 1);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        check("rst_words_loaded", 32'(words_loaded), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        exp_q.delete();
    endtask

    // Model: a length word in 1..MAXW produces one write per data word regardless of checksum.
    task automatic run_image(input logic [31:0] len, input logic [31:0] w0, input logic [31:0] step,
                             input logic [31:0] cdelta, input int maxgap, input bit exp_done, input bit exp_err);
        logic [31:0] sum;
        bit          len_ok;
        do_reset();
        len_ok = (len != 0) && (len <= MAXW);
        sum = 0;
        if (len_ok)
            for (int i = 0; i < int'(len); i++) begin
                wr_t w;
                w.addr = i;
                w.data = w0 + 32'(i) * step;
                sum += w.data;
                exp_q.push_back(w);
            end
        send_word(len, maxgap);
        if (!len_ok) begin
            check("badlen_error", 32'(error), 1);
            check("badlen_in_ready", 32'(in_ready), 0);
        end else begin
            for (int i = 0; i < int'(len); i++) send_word(w0 + 32'(i) * step, maxgap);
            send_word(sum + cdelta, maxgap);
            check("end_done", 32'(done), 32'(exp_done));
            check("end_error", 32'(error), 32'(exp_err));
            check("end_core_rst", 32'(core_rst), 32'(!exp_done));
        end
        send_word(32'hFFFF_FFFF, 0);
        check("after_in_ready", 32'(in_ready), 0);
        check("after_done", 32'(done), 32'(exp_done));
        check("after_error", 32'(error), 32'(exp_err));
        check("words_loaded", 32'(words_loaded), len_ok ? len : 0);
        check("writes_pending", exp_q.size(), 0);
    endtask

    initial begin
        tbl[0] = '{32'd2, 32'h13, 32'h0050_0080, 32'd0, 0, 1'b1, 1'b0};
        tbl[1] = '{32'd2, 32'h13, 32'h0050_0080, 32'd1, 0, 1'b0, 1'b1};
        tbl[2] = '{32'd0, 32'h0, 32'h0, 32'd0, 0, 1'b0, 1'b1};
        tbl[3] = '{32'd1025, 32'h0, 32'h0, 32'd0, 0, 1'b0, 1'b1};
        tbl[4] = '{32'd2, 32'h13, 32'h0050_0080, 32'd0, 5, 1'b1, 1'b0};
        tbl[5] = '{32'd1, 32'hDEAD_BEEF, 32'h0, 32'd0, 2, 1'b1, 1'b0};
        tbl[6] = '{32'd1024, 32'h0, 32'h1, 32'd0, 0, 1'b1, 1'b0};

        @(negedge clk);
        for (int t = 0; t < 7; t++)
            run_image(tbl[t].len, tbl[t].w0, tbl[t].step, tbl[t].cdelta, tbl[t].maxgap,
                      tbl[t].exp_done, tbl[t].exp_err);

        // Fixed bytes from the example image, checking the exact write-pulse timing.
        do_reset();
        exp_q.push_back('{32'd0, 32'h0000_0013});
        exp_q.push_back('{32'd1, 32'h0050_0093});
        send_word(32'd2, 0);
        send_word(32'h0000_0013, 0);
        check("pulse_w0", 32'(imem_we), 1);
        send_word(32'h0050_0093, 0);
        check("pulse_w1", 32'(imem_we), 1);
        check("pulse_wl", 32'(words_loaded), 2);
        send_byte(8'hA6, 0);
        check("pulse_gone", 32'(imem_we), 0);
        send_byte(8'h00, 0);
        send_byte(8'h50, 0);
        check("not_done_yet", 32'(done), 0);
        send_byte(8'h00, 0);
        check("done_next_cycle", 32'(done), 1);
        check("core_released", 32'(core_rst), 0);

        // Full image checksum value is sum(0..1023).
        check("full_csum_const", 32'(MAXW * (MAXW - 1) / 2), 32'h0007_FE00);

        // Reset after 3 of 5 words, then a fresh single-word image.
        do_reset();
        for (int i = 0; i < 3; i++) exp_q.push_back('{32'(i), 32'h100 + 32'(i)});
        send_word(32'd5, 1);
        for (int i = 0; i < 3; i++) send_word(32'h100 + 32'(i), 1);
        check("midload_wl", 32'(words_loaded), 3);
        do_reset();
        exp_q.push_back('{32'd0, 32'hDEAD_BEEF});
        send_word(32'd1, 0);
        send_word(32'hDEAD_BEEF, 0);
        send_word(32'hDEAD_BEEF, 0);
        check("fresh_done", 32'(done), 1);
        check("fresh_wl", 32'(words_loaded), 1);
        check("fresh_pending", exp_q.size(), 0);

        // Randomized images, lengths and checksum corruption.
        for (int r = 0; r < 25; r++) begin
            logic [31:0] len, cd;
            bit          ok;
            int          pick;
            pick = $urandom_range(0, 9);
            len  = (pick == 0) ? 32'd0 : (pick == 1) ? 32'd1025 + $urandom_range(0, 5000) : $urandom_range(1, 8);
            cd   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 1000) : 32'd0;
            ok   = (len != 0) && (len <= MAXW);
            run_image(len, $urandom, $urandom, cd, $urandom_range(0, 5), ok && cd == 0, !(ok && cd == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
